// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i core's fetch and load/store paths.
package rv32i_pkg;

  // addi x0,x0,0 -- safe filler while no instruction word is held
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Number of byte beats that make up one 32-bit word
  localparam int BYTES_PER_WORD = 4;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ERR
  } fetch_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian 4-beat byte-to-word assembler with a beat counter.
// 'assembled' is the word including the byte presented this cycle, so the
// caller can capture a complete word in the same cycle that 'done' pulses.
// Shared with the data-side load path.
module byte_assembler
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [31:0] assembled,
  output logic [1:0]  beat,
  output logic        done
);

  logic [31:0] word;

  // Insert the incoming byte at the lane selected by the current beat
  always_comb begin
    assembled = word;
    assembled[{beat, 3'b000} +: 8] = din;
  end

  assign done = load && (beat == 2'(BYTES_PER_WORD - 1));

  // Hold the partial word and advance the beat; clear restarts at lane 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word <= '0;
      beat <= '0;
    end else if (clear) begin
      beat <= '0;
    end else if (load) begin
      word <= assembled;
      beat <= beat + 2'd1;
    end
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch responder: serves the core's pc from a one-word buffer
// tagged by word address, refilling it over an 8-bit req/ack memory port.
// Optional feature: define IMEM_FETCH_PREFETCH_EN to add a second buffer that
// prefetches the next sequential word while the core is hitting.
module imem_fetch #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic              stall,
  output logic              misaligned,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);
  import rv32i_pkg::*;

  localparam int TW = ADDR_W - 2;

  fetch_state_t  state, state_nx;
  logic [TW-1:0] pc_word;
  logic [TW-1:0] fa, fa_nx;
  logic [TW-1:0] tag, tag_nx;
  logic          tag_valid, tag_valid_nx;
  logic [31:0]   buffer, buffer_nx;
  logic          mis_q, mis_nx;
  logic          pc_aligned;
  logic          hit;
  logic          moved;
  logic          load;
  logic          asm_clear;
  logic          asm_done;
  logic [31:0]   asm_word;
  logic [1:0]    beat;

`ifdef IMEM_FETCH_PREFETCH_EN
  logic [31:0]   pf, pf_nx;
  logic [TW-1:0] pf_tag, pf_tag_nx;
  logic          pf_valid, pf_valid_nx;
  logic          pf_mode, pf_mode_nx;
`endif

  assign pc_word    = pc[ADDR_W-1:2];
  assign pc_aligned = (pc[1:0] == 2'b00);
  assign moved      = (pc_word != fa) || !pc_aligned;

  // Hit is purely combinational on pc so a buffered word costs no latency
  assign hit = tag_valid && (tag == pc_word) && pc_aligned && (state != ERR);

  assign instr_valid = hit;
  assign stall       = !hit;
  assign instruction = hit ? buffer : NOP_WORD;
  assign misaligned  = mis_q;

  // Request lines come straight from the state so an async reset drops them at once
  assign mem_req  = (state == FETCH);
  assign mem_addr = {fa, beat};
  assign load     = mem_req && mem_ack;

  byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .load      (load),
    .din       (mem_rdata),
    .assembled (asm_word),
    .beat      (beat),
    .done      (asm_done)
  );

  // Fetch sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: start, restart, abandon or complete word fetches
  always_comb begin
    state_nx     = state;
    fa_nx        = fa;
    tag_nx       = tag;
    tag_valid_nx = tag_valid;
    buffer_nx    = buffer;
    mis_nx       = mis_q;
    asm_clear    = 1'b0;
`ifdef IMEM_FETCH_PREFETCH_EN
    pf_nx        = pf;
    pf_tag_nx    = pf_tag;
    pf_valid_nx  = pf_valid;
    pf_mode_nx   = pf_mode;
`endif
    case (state)
      IDLE: begin
        if (!pc_aligned) begin
          state_nx = ERR;
          mis_nx   = 1'b1;
        end else if (!hit) begin
`ifdef IMEM_FETCH_PREFETCH_EN
          if (pf_valid && (pf_tag == pc_word)) begin
            buffer_nx    = pf;
            tag_nx       = pf_tag;
            tag_valid_nx = 1'b1;
            pf_valid_nx  = 1'b0;
          end else begin
            state_nx     = FETCH;
            fa_nx        = pc_word;
            tag_valid_nx = 1'b0;
            asm_clear    = 1'b1;
            pf_mode_nx   = 1'b0;
          end
`else
          state_nx     = FETCH;
          fa_nx        = pc_word;
          tag_valid_nx = 1'b0;
          asm_clear    = 1'b1;
`endif
        end
`ifdef IMEM_FETCH_PREFETCH_EN
        else if (!(pf_valid && (pf_tag == tag + TW'(1)))) begin
          state_nx    = FETCH;
          fa_nx       = tag + TW'(1);
          pf_valid_nx = 1'b0;
          pf_mode_nx  = 1'b1;
          asm_clear   = 1'b1;
        end
`endif
      end

      FETCH: begin
`ifdef IMEM_FETCH_PREFETCH_EN
        if (pf_mode) begin
          if (load) begin
            if (!hit) begin
              asm_clear = 1'b1;
              state_nx  = IDLE;
            end else if (asm_done) begin
              pf_nx       = asm_word;
              pf_tag_nx   = fa;
              pf_valid_nx = 1'b1;
              state_nx    = IDLE;
            end
          end
        end else
`endif
        if (load) begin
          if (moved) begin
            asm_clear = 1'b1;
            if (!pc_aligned) begin
              state_nx = ERR;
              mis_nx   = 1'b1;
            end else begin
              fa_nx = pc_word;
            end
          end else if (asm_done) begin
            tag_nx       = fa;
            tag_valid_nx = 1'b1;
            buffer_nx    = asm_word;
            state_nx     = IDLE;
          end
        end
      end

      ERR: begin
        state_nx = ERR;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Word buffer, tag and fetch address registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fa        <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
      buffer    <= '0;
      mis_q     <= 1'b0;
`ifdef IMEM_FETCH_PREFETCH_EN
      pf        <= '0;
      pf_tag    <= '0;
      pf_valid  <= 1'b0;
      pf_mode   <= 1'b0;
`endif
    end else begin
      fa        <= fa_nx;
      tag       <= tag_nx;
      tag_valid <= tag_valid_nx;
      buffer    <= buffer_nx;
      mis_q     <= mis_nx;
`ifdef IMEM_FETCH_PREFETCH_EN
      pf        <= pf_nx;
      pf_tag    <= pf_tag_nx;
      pf_valid  <= pf_valid_nx;
      pf_mode   <= pf_mode_nx;
`endif
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch with a byte memory responder and a
// request-stability monitor. Build with IMEM_FETCH_PREFETCH_EN to cover the
// prefetch buffer.
module tb_imem_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        stall;
  logic        misaligned;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:15];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          req_cycles = 0;
  int          stab_viol  = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] addr_log [$];

  int req_base;
  int viol_base;
  int log_base;

  always #5 clk = ~clk;

  imem_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .stall       (stall),
    .misaligned  (misaligned),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  // Byte memory: acks a held request ack_delay cycles after first seeing it
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
    end else if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem[mem_addr[3:0]];
        wait_cnt  <= 0;
        addr_log.push_back(mem_addr);
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Count request cycles and flag any request dropped or moved before its ack
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_req) req_cycles <= req_cycles + 1;
      if (prev_req && !prev_ack && (!mem_req || mem_addr != prev_addr))
        stab_viol <= stab_viol + 1;
    end
    prev_req  <= mem_req && !reset;
    prev_ack  <= mem_ack;
    prev_addr <= mem_addr;
  end

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
      $error("[TB] check %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset the DUT with a new pc and ack delay, then release on a falling edge
  task automatic applyStimulus(input logic [31:0] new_pc, input int delay);
    reset     = 1'b1;
    pc        = new_pc;
    ack_delay = delay;
    tick(2);
    req_base  = req_cycles;
    viol_base = stab_viol;
    log_base  = addr_log.size();
    reset     = 1'b0;
  endtask

  task automatic waitValid(input int limit, input string name);
    int n = 0;
    while (instr_valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(instr_valid), 64'd1);
  endtask

  task automatic checkLog(input string name, input int idx, input logic [31:0] expected);
    logic [31:0] got;
    got = (addr_log.size() > log_base + idx) ? addr_log[log_base + idx] : 32'hDEAD_BEEF;
    checkOutput(name, 64'(got), 64'(expected));
  endtask

  initial begin
    int held_reqs;
    int n;
    // word 0x0 = 0x00100513, word 0x4 = 0x00200593,
    // word 0x8 = 0x00A58633, word 0xC (and 0xFFFFFFFC) = 0x00300613
    mem[0]  = 8'h13; mem[1]  = 8'h05; mem[2]  = 8'h10; mem[3]  = 8'h00;
    mem[4]  = 8'h93; mem[5]  = 8'h05; mem[6]  = 8'h20; mem[7]  = 8'h00;
    mem[8]  = 8'h33; mem[9]  = 8'h86; mem[10] = 8'hA5; mem[11] = 8'h00;
    mem[12] = 8'h13; mem[13] = 8'h06; mem[14] = 8'h30; mem[15] = 8'h00;

    reset = 1'b1;
    pc    = 32'h0;
    tick(2);
    checkOutput("rst_instruction", 64'(instruction), 64'(NOP));
    checkOutput("rst_instr_valid", 64'(instr_valid), 64'd0);
    checkOutput("rst_stall",       64'(stall),       64'd1);
    checkOutput("rst_misaligned",  64'(misaligned),  64'd0);
    checkOutput("rst_mem_req",     64'(mem_req),     64'd0);
    checkOutput("rst_mem_addr",    64'(mem_addr),    64'd0);

    // Cold miss at pc 0: word appears on cycle 9
    applyStimulus(32'h0, 0);
    tick(8);
    checkOutput("fill_valid_c8", 64'(instr_valid), 64'd0);
    checkOutput("fill_stall_c8", 64'(stall),       64'd1);
    tick(1);
    checkOutput("fill_valid_c9", 64'(instr_valid), 64'd1);
    checkOutput("fill_instr_c9", 64'(instruction), 64'h0010_0513);
    checkOutput("fill_stall_c9", 64'(stall),       64'd0);
    checkLog("fill_addr0", 0, 32'h0);
    checkLog("fill_addr1", 1, 32'h1);
    checkLog("fill_addr2", 2, 32'h2);
    checkLog("fill_addr3", 3, 32'h3);

    // Hold pc: word stays, no demand traffic
    held_reqs = req_cycles;
    tick(20);
    checkOutput("hold_instr", 64'(instruction), 64'h0010_0513);
    checkOutput("hold_stall", 64'(stall),       64'd0);
`ifdef IMEM_FETCH_PREFETCH_EN
    checkOutput("hold_pf_reqs", 64'(req_cycles - held_reqs), 64'd8);
    checkLog("pf_addr4", 4, 32'h4);
    checkLog("pf_addr7", 7, 32'h7);
    held_reqs = req_cycles;
    pc = 32'h4;
    tick(1);
    checkOutput("pf_swap_valid", 64'(instr_valid), 64'd1);
    checkOutput("pf_swap_instr", 64'(instruction), 64'h0020_0593);
    checkOutput("pf_swap_noreq", 64'(req_cycles - held_reqs), 64'd0);
`else
    checkOutput("hold_no_req", 64'(req_cycles - held_reqs), 64'd0);
`endif

    // pc moves to 0x4 while beat 1 of word 0 is in handshake
    applyStimulus(32'h0, 0);
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr === 32'h1) && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput("mid_reach_beat1", 64'(mem_addr), 64'h1);
    pc = 32'h4;
    tick(1);
    checkOutput("mid_valid_early", 64'(instr_valid), 64'd0);
    waitValid(40, "mid_valid_timeout");
    checkOutput("mid_instr", 64'(instruction), 64'h0020_0593);
    checkLog("mid_addr0", 0, 32'h0);
    checkLog("mid_addr1", 1, 32'h1);
    checkLog("mid_addr2", 2, 32'h4);
    checkLog("mid_addr5", 5, 32'h7);

    // Misaligned pc: sticky error, never a request
    applyStimulus(32'h6, 0);
    tick(10);
    checkOutput("mis_flag",  64'(misaligned),  64'd1);
    checkOutput("mis_stall", 64'(stall),       64'd1);
    checkOutput("mis_valid", 64'(instr_valid), 64'd0);
    checkOutput("mis_instr", 64'(instruction), 64'(NOP));
    pc = 32'h0;
    tick(12);
    checkOutput("mis_sticky", 64'(misaligned), 64'd1);
    checkOutput("mis_stall_held", 64'(stall), 64'd1);
    checkOutput("mis_no_req", 64'(req_cycles - req_base), 64'd0);

    // Slow memory: three wait cycles per beat
    applyStimulus(32'h8, 3);
    waitValid(80, "slow_valid_timeout");
    checkOutput("slow_instr", 64'(instruction), 64'h00A5_8633);
    checkOutput("slow_stable", 64'(stab_viol - viol_base), 64'd0);
    checkLog("slow_addr0", 0, 32'h8);
    checkLog("slow_addr3", 3, 32'hB);

    // Top word: byte addresses must not carry past 0xFFFFFFFF
    applyStimulus(32'hFFFF_FFFC, 0);
    waitValid(40, "wrap_valid_timeout");
    checkOutput("wrap_instr", 64'(instruction), 64'h0030_0613);
    checkLog("wrap_addr0", 0, 32'hFFFF_FFFC);
    checkLog("wrap_addr3", 3, 32'hFFFF_FFFF);

    // Reset in the middle of a fetch drops the request without a clock
    applyStimulus(32'h0, 0);
    tick(3);
    checkOutput("abort_req_before", 64'(mem_req), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_req_after",  64'(mem_req),  64'd0);
    checkOutput("abort_addr_after", 64'(mem_addr), 64'd0);
    tick(2);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
